// File: rtl/mul_seq_pkg.sv
// Shared types and widths for the sequential 8x4-core wide multiplier controller.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int A_CHUNK  = 8;
  localparam int B_CHUNK  = 4;
  localparam int CORE_P_W = 12;

endpackage

// File: rtl/mul_seq_ctrl_core.sv
// Purely combinational 8x4 unsigned multiplier core, time-shared by mul_seq_ctrl.
module mul8x4_core
  import mul_seq_pkg::*;
(
  input  logic [A_CHUNK-1:0]  a_i,
  input  logic [B_CHUNK-1:0]  b_i,
  output logic [CORE_P_W-1:0] p_o
);

  assign p_o = CORE_P_W'(a_i) * CORE_P_W'(b_i);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Wide unsigned multiplier that walks all 8x4 partial products through one core with shift-accumulate.
// Optional feature: define MUL_SEQ_ZERO_SKIP_EN to finish zero-operand requests without RUN cycles.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int A_W = 16,
  parameter int B_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     in_a,
  input  logic [B_W-1:0]     in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] out_p,
  output logic               busy
);

  localparam int NA  = A_W / A_CHUNK;
  localparam int NB  = B_W / B_CHUNK;
  localparam int NPP = NA * NB;
  localparam int P_W = A_W + B_W;
  localparam int KW  = (NPP > 1) ? $clog2(NPP) : 1;

  generate
    if ((A_W % A_CHUNK) != 0 || A_W <= 0) begin : g_bad_a_w
      $error("mul_seq_ctrl: A_W must be a positive multiple of 8");
    end
    if ((B_W % B_CHUNK) != 0 || B_W <= 0) begin : g_bad_b_w
      $error("mul_seq_ctrl: B_W must be a positive multiple of 4");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q;
  logic [A_W-1:0]      a_q;
  logic [B_W-1:0]      b_q;
  logic [P_W-1:0]      acc_q;

  logic                accept;
  logic                lastPp;
  logic                zeroOp;
  int                  aIdx;
  int                  bIdx;
  int                  shiftAmt;
  logic [A_CHUNK-1:0]  coreA;
  logic [B_CHUNK-1:0]  coreB;
  logic [CORE_P_W-1:0] coreP;
  logic [P_W-1:0]      ppShifted;

  assign accept = in_valid && in_ready;
  assign lastPp = (k_q == KW'(NPP - 1));

`ifdef MUL_SEQ_ZERO_SKIP_EN
  assign zeroOp = (in_a == '0) || (in_b == '0);
`else
  assign zeroOp = 1'b0;
`endif

  // k walks A chunks fastest, so each partial product lands at bit 8i+4j.
  always_comb begin
    aIdx      = int'(k_q) % NA;
    bIdx      = int'(k_q) / NA;
    shiftAmt  = aIdx * A_CHUNK + bIdx * B_CHUNK;
    coreA     = a_q[aIdx*A_CHUNK +: A_CHUNK];
    coreB     = b_q[bIdx*B_CHUNK +: B_CHUNK];
    ppShifted = P_W'(coreP) << shiftAmt;
  end

  mul8x4_core u_core (
    .a_i (coreA),
    .b_i (coreB),
    .p_o (coreP)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (accept) begin
      k_q   <= '0;
      a_q   <= in_a;
      b_q   <= in_b;
      acc_q <= '0;
    end else if (state_q == RUN) begin
      k_q   <= k_q + KW'(1);
      acc_q <= acc_q + ppShifted;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = zeroOp ? DONE : RUN;
      RUN:  if (lastPp) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
  end

  // The accumulator doubles as the result register, so the last product stays visible in IDLE.
  assign out_p = acc_q;

endmodule
